// File: rtl/cv32e40p_if_id_queue.sv
// ---------------------------------------------------------------------------
// cv32e40p_if_id_queue
// IF/ID decoupling queue. Entry 0 is the ID-facing output register; the
// remaining DEPTH-1 entries form an in-order FIFO that lets fetch run ahead
// of ID stalls. DEPTH=1 degenerates to the legacy single IF/ID register.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   setback_i                  clear all packets and zero the payload
//   flush_i                    discard all packets, payload held
//   halt_if_i                  block acceptance of new packets
//   in_valid_i / in_ready_o    packet handshake from IF (in_ready_o is comb)
//   in_*_i                     packet payload from the aligner/decompressor
//   instr_valid_id_o, *_id_o   output register towards ID
//   id_ready_i                 ID consumes the output packet
//   occ_o, afull_o, full_o     registered occupancy and throttle flags
// ---------------------------------------------------------------------------
module cv32e40p_if_id_queue #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         setback_i,
   input  logic                         flush_i,
   input  logic                         halt_if_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [31:0]                  in_instr_i,
   input  logic [31:0]                  in_pc_i,
   input  logic                         in_compressed_i,
   input  logic                         in_illegal_c_i,
   input  logic                         in_fetch_err_i,
   output logic                         instr_valid_id_o,
   output logic [31:0]                  instr_rdata_id_o,
   output logic [31:0]                  pc_id_o,
   output logic                         is_compressed_id_o,
   output logic                         illegal_c_insn_id_o,
   output logic                         is_fetch_failed_o,
   input  logic                         id_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   occ_o,
   output logic                         afull_o,
   output logic                         full_o
);

   localparam int unsigned OCC_W = $clog2(DEPTH + 1);
   localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] AFULL_V = OCC_W'(AFULL_THRESH);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        compressed;
      logic        illegal_c;
      logic        fetch_err;
   } pkt_t;

   pkt_t             in_pkt;
   pkt_t             out_q, out_d;
   logic             valid_q, valid_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             afull_q, full_q;

   logic             pop, push, load_slot;
   logic             fifo_empty, fifo_wr, fifo_rd, fifo_clr;
   pkt_t             fifo_head;

   assign in_pkt = '{instr:      in_instr_i,
                     pc:         in_pc_i,
                     compressed: in_compressed_i,
                     illegal_c:  in_illegal_c_i,
                     fetch_err:  in_fetch_err_i};

   // Handshakes; a pop frees a slot for a same-cycle push even when full
   assign pop        = valid_q & id_ready_i;
   assign in_ready_o = ~halt_if_i & ~flush_i & ~setback_i & ((occ_q < DEPTH_V) | pop);
   assign push       = in_valid_i & in_ready_o;
   assign load_slot  = pop | ~valid_q;

   // Next-state for output register, occupancy and FIFO control
   always_comb begin
      out_d    = out_q;
      valid_d  = valid_q;
      occ_d    = occ_q;
      fifo_wr  = 1'b0;
      fifo_rd  = 1'b0;
      fifo_clr = 1'b0;
      if (setback_i) begin
         out_d    = '0;
         valid_d  = 1'b0;
         occ_d    = '0;
         fifo_clr = 1'b1;
      end else if (flush_i) begin
         valid_d  = 1'b0;
         occ_d    = '0;
         fifo_clr = 1'b1;
      end else begin
         occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
         if (load_slot) begin
            // Older FIFO entries always go first to keep strict ordering
            if (!fifo_empty) begin
               out_d   = fifo_head;
               valid_d = 1'b1;
               fifo_rd = 1'b1;
            end else if (push) begin
               out_d   = in_pkt;
               valid_d = 1'b1;
            end else begin
               valid_d = 1'b0;
            end
         end
         fifo_wr = push & ~(load_slot & fifo_empty);
      end
   end

   // Output register and registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         valid_q <= 1'b0;
         occ_q   <= '0;
         afull_q <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
         occ_q   <= occ_d;
         afull_q <= (occ_d >= AFULL_V);
         full_q  <= (occ_d == DEPTH_V);
      end
   end

   // Internal FIFO storage (DEPTH-1 entries, modulo pointers)
   if (DEPTH > 1) begin : gen_fifo
      localparam int unsigned FD    = DEPTH - 1;
      localparam int unsigned PTR_W = (FD > 1) ? $clog2(FD) : 1;
      localparam int unsigned CNT_W = $clog2(FD + 1);
      localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FD - 1);

      pkt_t             mem_q [FD];
      logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
      logic [CNT_W-1:0] cnt_q;

      assign fifo_empty = (cnt_q == '0);
      assign fifo_head  = mem_q[rd_ptr_q];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else if (fifo_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            if (fifo_wr) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            if (fifo_rd) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
         end
      end

      // Payload storage needs no reset; the count guards every read
      always_ff @(posedge clk) begin
         if (fifo_wr) mem_q[wr_ptr_q] <= in_pkt;
      end
   end else begin : gen_no_fifo
      assign fifo_empty = 1'b1;
      assign fifo_head  = '0;
   end

   assign instr_valid_id_o    = valid_q;
   assign instr_rdata_id_o    = out_q.instr;
   assign pc_id_o             = out_q.pc;
   assign is_compressed_id_o  = out_q.compressed;
   assign illegal_c_insn_id_o = out_q.illegal_c;
   assign is_fetch_failed_o   = out_q.fetch_err;
   assign occ_o               = occ_q;
   assign afull_o             = afull_q;
   assign full_o              = full_q;

endmodule

// File: tb/tb_cv32e40p_if_id_queue.sv
// Bench for cv32e40p_if_id_queue: three instances (DEPTH 4/3/1) checked
// against a queue-based reference model, one instance active at a time.
module tb_cv32e40p_if_id_queue;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [2:0]  setback, flush, halt, in_valid, id_ready;
   logic [31:0] in_instr, in_pc;
   logic        in_comp, in_ill, in_ferr;
   logic [2:0]  in_ready, valid, comp_o, ill_o, ferr_o, afull, full;
   logic [31:0] instr_o [3];
   logic [31:0] pc_o [3];
   logic [2:0]  occ0;
   logic [1:0]  occ1;
   logic [0:0]  occ2;

   cv32e40p_if_id_queue #(.DEPTH(4), .AFULL_THRESH(3)) u_d4 (
      .clk(clk), .rst_n(rst_n), .setback_i(setback[0]), .flush_i(flush[0]),
      .halt_if_i(halt[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
      .in_instr_i(in_instr), .in_pc_i(in_pc), .in_compressed_i(in_comp),
      .in_illegal_c_i(in_ill), .in_fetch_err_i(in_ferr),
      .instr_valid_id_o(valid[0]), .instr_rdata_id_o(instr_o[0]), .pc_id_o(pc_o[0]),
      .is_compressed_id_o(comp_o[0]), .illegal_c_insn_id_o(ill_o[0]),
      .is_fetch_failed_o(ferr_o[0]), .id_ready_i(id_ready[0]),
      .occ_o(occ0), .afull_o(afull[0]), .full_o(full[0]));

   cv32e40p_if_id_queue #(.DEPTH(3), .AFULL_THRESH(2)) u_d3 (
      .clk(clk), .rst_n(rst_n), .setback_i(setback[1]), .flush_i(flush[1]),
      .halt_if_i(halt[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
      .in_instr_i(in_instr), .in_pc_i(in_pc), .in_compressed_i(in_comp),
      .in_illegal_c_i(in_ill), .in_fetch_err_i(in_ferr),
      .instr_valid_id_o(valid[1]), .instr_rdata_id_o(instr_o[1]), .pc_id_o(pc_o[1]),
      .is_compressed_id_o(comp_o[1]), .illegal_c_insn_id_o(ill_o[1]),
      .is_fetch_failed_o(ferr_o[1]), .id_ready_i(id_ready[1]),
      .occ_o(occ1), .afull_o(afull[1]), .full_o(full[1]));

   cv32e40p_if_id_queue #(.DEPTH(1), .AFULL_THRESH(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .setback_i(setback[2]), .flush_i(flush[2]),
      .halt_if_i(halt[2]), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
      .in_instr_i(in_instr), .in_pc_i(in_pc), .in_compressed_i(in_comp),
      .in_illegal_c_i(in_ill), .in_fetch_err_i(in_ferr),
      .instr_valid_id_o(valid[2]), .instr_rdata_id_o(instr_o[2]), .pc_id_o(pc_o[2]),
      .is_compressed_id_o(comp_o[2]), .illegal_c_insn_id_o(ill_o[2]),
      .is_fetch_failed_o(ferr_o[2]), .id_ready_i(id_ready[2]),
      .occ_o(occ2), .afull_o(afull[2]), .full_o(full[2]));

   // Reference model: the whole queue as a FIFO list, head = what ID sees
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        c;
      logic        i;
      logic        f;
   } pkt_t;

   pkt_t        mq[$];
   pkt_t        last;
   logic [31:0] obs_pc[$];
   int          cur;
   int          n_assert;
   int          n_fail;
   logic [31:0] next_pc;

   function automatic int dep(int k);
      return (k == 0) ? 4 : (k == 1) ? 3 : 1;
   endfunction

   function automatic int thr(int k);
      return (k == 0) ? 3 : (k == 1) ? 2 : 1;
   endfunction

   function automatic logic m_ready();
      return !halt[cur] && !flush[cur] && !setback[cur] &&
             ((mq.size() < dep(cur)) || (mq.size() > 0 && id_ready[cur]));
   endfunction

   function automatic logic [31:0] occ_obs();
      case (cur)
         0:       return 32'(occ0);
         1:       return 32'(occ1);
         default: return 32'(occ2);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut=%0d observed=%h expected=%h", tag, cur, obs, exp);
      end
   endtask

   task automatic check_all();
      pkt_t e;
      e = (mq.size() > 0) ? mq[0] : last;
      chk("in_ready", 32'(in_ready[cur]), 32'(m_ready()));
      chk("valid",    32'(valid[cur]),    32'(mq.size() > 0));
      chk("occ",      occ_obs(),          32'(mq.size()));
      chk("afull",    32'(afull[cur]),    32'(mq.size() >= thr(cur)));
      chk("full",     32'(full[cur]),     32'(mq.size() == dep(cur)));
      chk("instr",    instr_o[cur],       e.instr);
      chk("pc",       pc_o[cur],          e.pc);
      chk("comp",     32'(comp_o[cur]),   32'(e.c));
      chk("illegal",  32'(ill_o[cur]),    32'(e.i));
      chk("ferr",     32'(ferr_o[cur]),   32'(e.f));
   endtask

   task automatic idle_all();
      setback = '0; flush = '0; halt = '0; in_valid = '0; id_ready = '0;
   endtask

   task automatic drive(input logic v, input logic r, input logic h, input logic fl,
                        input logic sb, input logic [31:0] pc, input logic [2:0] fl3);
      in_valid[cur] = v;  id_ready[cur] = r; halt[cur] = h;
      flush[cur]    = fl; setback[cur]  = sb;
      in_pc    = pc;
      in_instr = $urandom;
      {in_comp, in_ill, in_ferr} = fl3;
   endtask

   // One clock: check pre-edge state, then advance the model with the inputs
   task automatic step();
      logic rdy, pop, push;
      pkt_t p;
      #1;
      check_all();
      rdy  = m_ready();
      pop  = (mq.size() > 0) && id_ready[cur];
      push = in_valid[cur] && rdy;
      if (valid[cur] && id_ready[cur]) obs_pc.push_back(pc_o[cur]);
      p = '{instr: in_instr, pc: in_pc, c: in_comp, i: in_ill, f: in_ferr};
      @(posedge clk);
      if (setback[cur]) begin
         mq.delete();
         last = '0;
      end else if (flush[cur]) begin
         if (mq.size() > 0) last = mq[0];
         mq.delete();
      end else begin
         if (pop)  last = mq.pop_front();
         if (push) mq.push_back(p);
      end
      @(negedge clk);
   endtask

   // Asynchronous reset in the middle of a cycle; checked before any edge
   task automatic async_reset();
      int save;
      save = cur;
      idle_all();
      #2 rst_n = 1'b0;
      mq.delete();
      last = '0;
      #1;
      for (int k = 0; k < 3; k++) begin
         cur = k;
         check_all();
      end
      cur = save;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_run(input int ncyc, input logic ctl);
      logic v;
      for (int n = 0; n < ncyc; n++) begin
         v = ($urandom_range(3) != 0);
         drive(v, 1'($urandom), ($urandom_range(7) == 0),
               ctl && ($urandom_range(15) == 0), ctl && ($urandom_range(31) == 0),
               next_pc, 3'($urandom));
         if (v && m_ready()) next_pc += 32'd4;
         step();
      end
   endtask

   initial begin
      int acc;
      int cyc;
      n_assert = 0; n_fail = 0; cur = 0; last = '0; next_pc = 32'h1000;
      in_instr = '0; in_pc = '0; in_comp = 1'b0; in_ill = 1'b0; in_ferr = 1'b0;
      idle_all();
      rst_n = 1'b0;
      #3;
      for (int k = 0; k < 3; k++) begin
         cur = k;
         check_all();
      end
      @(negedge clk);
      rst_n = 1'b1;

      // DEPTH=4: fill with ID stalled, then drain in order
      cur = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80 + 32'(4 * i), 3'b000);
         step();
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h90, 3'b000);
      step();
      chk("d4_full_occ", occ_obs(), 32'd4);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
         step();
      end
      chk("d4_drained_pc", pc_o[0], 32'h8C);

      // Flush mid-stream with a packet offered
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200 + 32'(4 * i), 3'b000);
         step();
      end
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 3'b000);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
      step();
      chk("flush_pc_held", pc_o[0], 32'h200);

      // Setback zeros the held payload
      in_instr = 32'h13;
      in_valid[0] = 1'b1; in_pc = 32'h100; {in_comp, in_ill, in_ferr} = 3'b000;
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 3'b000);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
      step();
      chk("setback_instr", instr_o[0], 32'h0);

      // Halt: new packets refused, queue drains through ID
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400 + 32'(4 * i), 3'b000);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 3'b000);
         step();
      end

      // Random traffic with flush/setback on DEPTH=4, then async reset mid-op
      rand_run(150, 1'b1);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600 + 32'(4 * i), 3'b111);
         step();
      end
      async_reset();

      // DEPTH=3: 50 packets under random ID stalls, strictly in order
      cur = 1;
      next_pc = 32'h1000;
      obs_pc.delete();
      acc = 0; cyc = 0;
      while (acc < 50 && cyc < 2000) begin
         drive(($urandom_range(3) != 0), 1'($urandom), 1'b0, 1'b0, 1'b0, next_pc, 3'($urandom));
         if (in_valid[1] && m_ready()) begin
            next_pc += 32'd4;
            acc++;
         end
         step();
         cyc++;
      end
      cyc = 0;
      while (mq.size() > 0 && cyc < 100) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
         step();
         cyc++;
      end
      chk("d3_accepted", 32'(acc), 32'd50);
      chk("d3_popped", 32'(obs_pc.size()), 32'd50);
      for (int i = 0; i < obs_pc.size(); i++)
         chk("d3_order", obs_pc[i], 32'h1000 + 32'(4 * i));
      async_reset();

      // DEPTH=1: flags propagate, full+pop accepts same cycle
      cur = 2;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h700, 3'b111);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h704, 3'b010);
      step();
      chk("d1_next_pc", pc_o[2], 32'h704);
      next_pc = 32'h2000;
      rand_run(150, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cv32e40p_if_id_queue.md
# cv32e40p_if_id_queue

Parametrised IF/ID decoupling queue that replaces the single-entry IF/ID pipeline register of the fetch stage. It accepts decoded-ready instruction packets (decompressed instruction, PC, compressed/illegal/fetch-error flags) from the aligner/compressed-decoder path. It presents them in order to the ID stage. DEPTH=1 reproduces the legacy single-register behaviour. Larger DEPTH lets fetch run ahead of ID stalls, and an almost-full flag throttles the prefetcher.

## Interface
- DEPTH, 2: total packet capacity (≥1); entry 0 is the ID-facing output register, DEPTH-1 entries are internal FIFO storage; non-power-of-2 allowed
- AFULL_THRESH, DEPTH-1: occupancy at or above which afull_o asserts (1..DEPTH)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- setback_i  in  1  synchronous full clear (valid and payload to zero)
- flush_i  in  1  synchronous discard of all packets (driven by pc_set / clear_instr_valid)
- halt_if_i  in  1  blocks acceptance of new packets
- in_valid_i  in  1  packet offered by IF
- in_ready_o  out  1  packet accepted this cycle when in_valid_i & in_ready_o
- in_instr_i  in  32  decompressed instruction
- in_pc_i  in  32  instruction PC
- in_compressed_i  in  1  original was compressed
- in_illegal_c_i  in  1  illegal compressed encoding
- in_fetch_err_i  in  1  fetch failed for this packet
- instr_valid_id_o  out  1  output register holds a valid packet
- instr_rdata_id_o  out  32  output instruction
- pc_id_o  out  32  output PC
- is_compressed_id_o  out  1  output compressed flag
- illegal_c_insn_id_o  out  1  output illegal flag
- is_fetch_failed_o  out  1  output fetch-error flag
- id_ready_i  in  1  ID consumes the output packet when instr_valid_id_o & id_ready_i
- occ_o  out  $clog2(DEPTH+1)  packets held (output reg + FIFO)
- afull_o  out  1  occ_o ≥ AFULL_THRESH
- full_o  out  1  occ_o == DEPTH

## Operation
- pop = instr_valid_id_o & id_ready_i; push = in_valid_i & in_ready_o.
- in_ready_o = ~halt_if_i & ~flush_i & ~setback_i & (occ_o < DEPTH | pop). This is a combinational path from id_ready_i, which is required.
- Output register load: on pop or when invalid, load the FIFO head if FIFO is non-empty. Otherwise load the pushed packet directly if push. Otherwise clear valid only.
- FIFO: write at wr_ptr when push and the packet does not go straight to the output register. Read at rd_ptr on refill. Pointers wrap at DEPTH-1 (modulo, not power-of-2 masking). The FIFO count is tracked explicitly.
- Strict in-order delivery; a packet never bypasses an older one.
- When instr_valid_id_o=0, payload outputs hold the last loaded packet, which is needed for pc_id_o-relative FENCE.I. Exception: after reset or setback, all payload outputs are 0.
- flush_i: next cycle occ_o=0 and instr_valid_id_o=0; payload held; same-cycle push is not accepted (in_ready_o=0); pop still reported to ID that cycle.
- setback_i: as flush, and additionally all payload outputs go to 0. Priority: rst_n > setback_i > flush_i > push/pop.
- DEPTH=1: no FIFO storage is generated. in_ready_o = ~halt_if_i & ~flush_i & ~setback_i & (~instr_valid_id_o | id_ready_i).
- Arithmetic: occ_o next = occ_o + push − pop, saturating is never needed. The bench asserts 0 ≤ occ_o ≤ DEPTH.

## Timing
- Reset values: instr_valid_id_o=0, all payload outputs 0, occ_o=0, afull_o=0 (AFULL_THRESH≥1), full_o=0, pointers 0. in_ready_o follows its equation (1 when halt_if_i=0, flush_i=0, setback_i=0).
- Latency push→instr_valid_id_o: 1 cycle when the output register is empty or popping and the FIFO is empty.
- Throughput: 1 packet/cycle sustained with id_ready_i=1, any DEPTH.
- Full with simultaneous pop: push accepted, occ_o unchanged.
- Empty with no push: instr_valid_id_o falls the cycle after the last pop.
- occ_o, afull_o and full_o are registered and reflect state after the previous edge.
- Reset asserted mid-operation: all state clears immediately (asynchronously). Packets in flight are lost; no partial packet is ever presented.

## Test plan
- DEPTH=4: push PCs 0x80,0x84,0x88,0x8C with id_ready_i=0 → occ_o=4, full_o=1, in_ready_o=0. Then id_ready_i=1 for 4 cycles → PCs pop in order, occ_o back to 0.
- DEPTH=3 wrap: continuous push/pop with id_ready_i toggling pseudo-randomly for 50 packets → exact in-order PC sequence, occ_o never >3, no drops.
- Flush mid-stream: occ_o=3, assert flush_i with in_valid_i=1 → in_ready_o=0, next cycle instr_valid_id_o=0, occ_o=0, pc_id_o unchanged.
- Setback: valid packet instr=0x00000013 pc=0x100 held, setback_i=1 → next cycle valid=0, instr_rdata_id_o=0, pc_id_o=0, occ_o=0.
- Halt: halt_if_i=1 with in_valid_i=1 → in_ready_o=0, queue drains normally via id_ready_i.
- DEPTH=1 with full & id_ready_i=1 → new packet accepted same cycle, visible next cycle. Flags (compressed=1, illegal=1, fetch_err=1) propagate unchanged; afull_o with AFULL_THRESH=1 tracks instr_valid_id_o.
